// File: rtl/lt24_touch_spi_sampler_if.sv
// Avalon-MM slave bus bundle for the LT24 touch sampler.
// Master drives address/strobes; slave returns registered readdata.
interface lt24_touch_spi_sampler_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/lt24_touch_spi_sampler.sv
// LT24 touch ADC sampler: SPI X/Y conversions while pen is down.
// Define TOUCH_AVG_EN to average four conversions per axis.
module lt24_touch_spi_sampler #(
  parameter int unsigned CLK_DIV    = 25,
  parameter int unsigned GAP_CYCLES = 50000,
  parameter logic [7:0]  CMD_X      = 8'hD0,
  parameter logic [7:0]  CMD_Y      = 8'h90
) (
  input  logic clk,
  input  logic reset_n,
  lt24_touch_spi_sampler_if.slave bus,
  output logic irq,
  input  logic pen_irq_n,
  output logic touch_dclk,
  output logic touch_cs_n,
  output logic touch_din,
  input  logic touch_dout,
  input  logic touch_busy
);

  typedef enum logic [2:0] {
    IDLE, CONV_X, CONV_Y, COMMIT, GAP
  } state_t;

  localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);

  state_t      state_q;
  logic [7:0]  div_q;
  logic [5:0]  half_q;
  logic [11:0] sh_q;
  logic [31:0] gap_q;
  logic [11:0] xs_q, ys_q, x_q, y_q;
  logic        enable_q, irq_en_q;
  logic        valid_q, overrun_q;
  logic        dclk_q, cs_n_q, din_q;
  logic        dclk_d, cs_n_d, din_d;
  logic [1:0]  pen_s_q, dout_s_q;
  logic [31:0] rdata_q;

  logic        pen_down, in_conv, busy;
  logic        half_end, conv_end, sample, wr_en;
  logic [7:0]  cmd;
  logic        axis_done;
  logic [11:0] axis_val;
  logic        unused_bits;

  assign pen_down = ~pen_s_q[1];
  assign in_conv  = state_q == CONV_X || state_q == CONV_Y;
  assign busy     = in_conv || state_q == COMMIT;
  assign half_end = div_q == DIV_LAST;
  assign conv_end = in_conv && half_end && half_q == 6'd50;
  // rising edges 10..21 begin on odd halves 19..41
  assign sample   = in_conv && half_end && half_q[0] &&
                    half_q >= 6'd19 && half_q <= 6'd41;
  assign cmd      = state_q == CONV_X ? CMD_X : CMD_Y;
  assign wr_en    = bus.chipselect && !bus.write_n;

  assign unused_bits = ^{touch_busy, bus.writedata[31:2]};

`ifdef TOUCH_AVG_EN
  logic [1:0]  nconv_q;
  logic [13:0] acc_q;
  logic [13:0] acc_sum;
  assign acc_sum   = acc_q + {2'b00, sh_q};
  assign axis_done = nconv_q == 2'd3;
  assign axis_val  = acc_sum[13:2];
`else
  assign axis_done = 1'b1;
  assign axis_val  = sh_q;
`endif

  // halves 0..49 hold cs_n low; half 50 is the cs_n-high spacer
  always_comb begin
    cs_n_d = 1'b1;
    dclk_d = 1'b0;
    din_d  = 1'b0;
    if (in_conv) begin
      cs_n_d = half_q > 6'd49;
      dclk_d = half_q[0] && half_q <= 6'd47;
      if (half_q < 6'd16) din_d = cmd[3'd7 - half_q[3:1]];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pen_s_q  <= 2'b11;
      dout_s_q <= 2'b00;
    end else begin
      pen_s_q  <= {pen_s_q[0], pen_irq_n};
      dout_s_q <= {dout_s_q[0], touch_dout};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      div_q     <= '0;
      half_q    <= '0;
      sh_q      <= '0;
      gap_q     <= '0;
      xs_q      <= '0;
      ys_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      enable_q  <= 1'b0;
      irq_en_q  <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      dclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      din_q     <= 1'b0;
`ifdef TOUCH_AVG_EN
      nconv_q   <= '0;
      acc_q     <= '0;
`endif
    end else begin
      dclk_q <= dclk_d;
      cs_n_q <= cs_n_d;
      din_q  <= din_d;
      if (wr_en && bus.address == 2'd2) begin
        enable_q <= bus.writedata[0];
        irq_en_q <= bus.writedata[1];
      end
      if (wr_en && bus.address == 2'd3) begin
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end
      if (in_conv) begin
        if (half_end) begin
          div_q  <= '0;
          half_q <= half_q + 6'd1;
        end else begin
          div_q <= div_q + 8'd1;
        end
        if (sample) sh_q <= {sh_q[10:0], dout_s_q[1]};
        if (conv_end) begin
          div_q  <= '0;
          half_q <= '0;
          sh_q   <= '0;
        end
      end
`ifdef TOUCH_AVG_EN
      if (conv_end) begin
        acc_q   <= axis_done ? '0 : acc_sum;
        nconv_q <= nconv_q + 2'd1;
      end
`endif
      unique case (state_q)
        IDLE: begin
          if (enable_q && pen_down) state_q <= CONV_X;
        end
        CONV_X: begin
          if (conv_end && axis_done) begin
            xs_q    <= axis_val;
            state_q <= CONV_Y;
          end
        end
        CONV_Y: begin
          if (conv_end && axis_done) begin
            ys_q    <= axis_val;
            state_q <= COMMIT;
          end
        end
        COMMIT: begin
          x_q       <= xs_q;
          y_q       <= ys_q;
          valid_q   <= 1'b1;
          overrun_q <= overrun_q | valid_q;
          gap_q     <= '0;
          state_q   <= GAP;
        end
        GAP: begin
          if (!pen_down || !enable_q) begin
            state_q <= IDLE;
          end else if (gap_q == GAP_LAST) begin
            gap_q   <= '0;
            state_q <= CONV_X;
          end else begin
            gap_q <= gap_q + 32'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else begin
      unique case (bus.address)
        2'd0: rdata_q <= {20'd0, x_q};
        2'd1: rdata_q <= {20'd0, y_q};
        2'd2: rdata_q <= {30'd0, irq_en_q, enable_q};
        2'd3: rdata_q <= {28'd0, overrun_q, pen_down,
                          busy, valid_q};
        default: rdata_q <= '0;
      endcase
    end
  end

  assign bus.readdata = rdata_q;
  assign irq          = valid_q & irq_en_q;
  assign touch_dclk   = dclk_q;
  assign touch_cs_n   = cs_n_q;
  assign touch_din    = din_q;

endmodule
